// File: rtl/viterbi_pkg.sv
// Shared helpers for the Viterbi ACS/path-metric engine: trellis sizing,
// encoder output, branch metric and saturating metric addition.
package viterbi_pkg;

    localparam int unsigned K_MAX  = 7;
    localparam int unsigned PM_MAX = 16;
    localparam int unsigned SUM_W  = PM_MAX + 1;

    function automatic int unsigned n_states(input int unsigned k);
        return 32'd1 << (k - 32'd1);
    endfunction

    // Encoder output symbol {c0,c1} for register contents r = {state, u}.
    function automatic logic [1:0] enc_out(input logic [K_MAX-1:0] r,
                                           input logic [K_MAX-1:0] g0,
                                           input logic [K_MAX-1:0] g1);
        return {^(r & g0), ^(r & g1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] bm_hamming(input logic [1:0] sym,
                                              input logic [1:0] expected);
        logic [1:0] d;
        d = sym ^ expected;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

    // Adds a branch metric to a w-bit metric, clamping at 2^w-1 (w <= PM_MAX).
    function automatic logic [PM_MAX-1:0] sat_add(input logic [PM_MAX-1:0] a,
                                                  input logic [1:0]        b,
                                                  input int unsigned       w);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        sum = {1'b0, a} + SUM_W'(b);
        lim = SUM_W'((32'd1 << w) - 32'd1);
        if (sum > lim) begin
            sum = lim;
        end
        return PM_MAX'(sum);
    endfunction

endpackage

// File: rtl/acs_butterfly.sv
// One next-state add-compare-select cell: adds branch metrics to both
// predecessor metrics and keeps the smaller, preferring p0 on ties.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int unsigned     K    = 3,
    parameter logic [K-1:0]    G0   = 3'b111,
    parameter logic [K-1:0]    G1   = 3'b101,
    parameter int unsigned     PM_W = 4,
    parameter int unsigned     NS   = 0
) (
    input  logic [PM_W-1:0] pm_p0_i,
    input  logic [PM_W-1:0] pm_p1_i,
    input  logic [1:0]      sym_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    localparam int unsigned P0 = NS >> 1;
    localparam int unsigned P1 = P0 + (32'd1 << (K - 2));
    localparam int unsigned U  = NS & 32'd1;
    localparam int unsigned R0 = (P0 << 1) | U;
    localparam int unsigned R1 = (P1 << 1) | U;

    localparam logic [1:0] EXP0 = enc_out(K_MAX'(R0), K_MAX'(G0), K_MAX'(G1));
    localparam logic [1:0] EXP1 = enc_out(K_MAX'(R1), K_MAX'(G0), K_MAX'(G1));

    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    always_comb begin
        bm0   = bm_hamming(sym_i, EXP0);
        bm1   = bm_hamming(sym_i, EXP1);
        cand0 = PM_W'(sat_add(PM_MAX'(pm_p0_i), bm0, PM_W));
        cand1 = PM_W'(sat_add(PM_MAX'(pm_p1_i), bm1, PM_W));
        if (cand1 < cand0) begin
            pm_o  = cand1;
            dec_o = 1'b1;
        end else begin
            pm_o  = cand0;
            dec_o = 1'b0;
        end
    end

endmodule

// File: rtl/acs_pm_engine.sv
// Path-metric engine for a rate-1/2 hard-decision Viterbi decoder: ACS over
// all states, normalisation, and best-state search, all updated per symbol.
module acs_pm_engine
    import viterbi_pkg::*;
#(
    parameter int unsigned  K    = 3,
    parameter logic [K-1:0] G0   = 3'b111,
    parameter logic [K-1:0] G1   = 3'b101,
    parameter int unsigned  PM_W = 4,
    localparam int unsigned N_ST = n_states(K)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_valid,
    input  logic [1:0]             i_data,
    output logic                   o_valid,
    output logic [N_ST-1:0]        o_dec,
    output logic [N_ST*PM_W-1:0]   o_pm,
    output logic [K-2:0]           o_best_state,
    output logic [PM_W-1:0]        o_best_pm,
    output logic                   o_norm
);

    localparam int unsigned   SW   = K - 1;
    localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

    logic [PM_W-1:0] pm_q [N_ST];
    logic [PM_W-1:0] pm_d [N_ST];
    logic [PM_W-1:0] sel_pm [N_ST];
    logic [N_ST-1:0] dec_c;
    logic [N_ST-1:0] dec_q,  dec_d;
    logic            valid_q, valid_d;
    logic            norm_q,  norm_d;
    logic [K-2:0]    bs_q,    bs_d;
    logic [PM_W-1:0] bpm_q,   bpm_d;

    logic [PM_W-1:0] min_pm;
    logic [K-2:0]    min_idx;
    logic            do_norm;

    for (genvar g = 0; g < N_ST; g++) begin : g_acs
        localparam int unsigned P0 = g >> 1;
        localparam int unsigned P1 = P0 + (32'd1 << (K - 2));
        acs_butterfly #(
            .K    (K),
            .G0   (G0),
            .G1   (G1),
            .PM_W (PM_W),
            .NS   (g)
        ) u_acs (
            .pm_p0_i (pm_q[P0]),
            .pm_p1_i (pm_q[P1]),
            .sym_i   (i_data),
            .pm_o    (sel_pm[g]),
            .dec_o   (dec_c[g])
        );
        assign o_pm[g*PM_W +: PM_W] = pm_q[g];
    end

    // Minimum over new metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        min_pm  = sel_pm[0];
        min_idx = '0;
        for (int unsigned i = 1; i < N_ST; i++) begin
            if (sel_pm[i] < min_pm) begin
                min_pm  = sel_pm[i];
                min_idx = SW'(i);
            end
        end
        do_norm = min_pm[PM_W-1];
    end

    always_comb begin
        pm_d    = pm_q;
        dec_d   = dec_q;
        valid_d = 1'b0;
        norm_d  = 1'b0;
        bs_d    = bs_q;
        bpm_d   = bpm_q;
        if (i_start) begin
            for (int unsigned i = 0; i < N_ST; i++) begin
                pm_d[i] = (i == 0) ? '0 : '1;
            end
        end else if (i_valid) begin
            for (int unsigned i = 0; i < N_ST; i++) begin
                pm_d[i] = do_norm ? (sel_pm[i] - HALF) : sel_pm[i];
            end
            dec_d   = dec_c;
            valid_d = 1'b1;
            norm_d  = do_norm;
            bs_d    = min_idx;
            bpm_d   = do_norm ? (min_pm - HALF) : min_pm;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N_ST; i++) begin
                pm_q[i] <= (i == 0) ? '0 : '1;
            end
            dec_q   <= '0;
            valid_q <= 1'b0;
            norm_q  <= 1'b0;
            bs_q    <= '0;
            bpm_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ST; i++) begin
                pm_q[i] <= pm_d[i];
            end
            dec_q   <= dec_d;
            valid_q <= valid_d;
            norm_q  <= norm_d;
            bs_q    <= bs_d;
            bpm_q   <= bpm_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_dec        = dec_q;
    assign o_best_state = bs_q;
    assign o_best_pm    = bpm_q;
    assign o_norm       = norm_q;

endmodule
